// File: rtl/interp_pkg.sv
// Shared mode encodings and width helper for the multichannel resampler.
package interp_pkg;

   localparam logic [1:0] MODE_HOLD    = 2'd0;
   localparam logic [1:0] MODE_NEAREST = 2'd1;
   localparam logic [1:0] MODE_LINEAR  = 2'd2;

   // Weight spans 1..2^fracbits inclusive, so it needs one bit beyond the fraction.
   function automatic int weight_width(input int fracbits);
      return fracbits + 1;
   endfunction

endpackage

// File: rtl/interp_lane.sv
// One resampler lane: prev/cur sample registers and the registered mode mux.
// RESAMPLER_ROUNDING_EN selects round-half-up for linear mode instead of floor.
module interp_lane
   import interp_pkg::*;
#(
   parameter int INW      = 16,
   parameter int FRACBITS = 8
) (
   input  logic                                i_clk,
   input  logic                                i_areset_n,
   input  logic                                i_ce,
   input  logic                                i_upd,
   input  logic [1:0]                          i_mode,
   input  logic [weight_width(FRACBITS)-1:0]   i_weight,
   input  logic [INW-1:0]                      i_data,
   output logic [INW-1:0]                      o_data
);

   localparam int WW = weight_width(FRACBITS);
   localparam int PW = INW + FRACBITS + 2;
   localparam logic [WW-1:0] HALF_W = WW'(1) << (FRACBITS - 1);
   localparam logic signed [PW-1:0] HALF_P = PW'(1) << (FRACBITS - 1);

   logic signed [INW-1:0] cur_q, prev_q, out_q, out_d;
   logic signed [INW:0]   diff;
   logic signed [PW-1:0]  diff_x, w_x, prod, prod_r, shifted, prev_x;

   assign diff   = {cur_q[INW-1], cur_q} - {prev_q[INW-1], prev_q};
   assign diff_x = {{(PW-INW-1){diff[INW]}}, diff};
   assign w_x    = {{(PW-WW){1'b0}}, i_weight};
   assign prod   = diff_x * w_x;
`ifdef RESAMPLER_ROUNDING_EN
   assign prod_r = prod + HALF_P;
`else
   assign prod_r = prod;
`endif
   assign shifted = prod_r >>> FRACBITS;
   assign prev_x  = {{(PW-INW){prev_q[INW-1]}}, prev_q};

   always_comb begin
      out_d = cur_q;
      case (i_mode)
         MODE_NEAREST: out_d = (i_weight >= HALF_W) ? cur_q : prev_q;
         // w <= 2^FRACBITS keeps the result between prev and cur, so truncation is lossless
         MODE_LINEAR:  out_d = INW'(prev_x + shifted);
         default:      out_d = cur_q;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         cur_q  <= '0;
         prev_q <= '0;
         out_q  <= '0;
      end else begin
         if (i_ce) begin
            prev_q <= cur_q;
            cur_q  <= i_data;
         end
         if (i_upd) out_q <= out_d;
      end
   end

   assign o_data = out_q;

endmodule

// File: rtl/multichan_resampler.sv
// Phase-accumulator resampler for NCH lanes sharing one strobe; hold/nearest/linear modes.
// Optional RESAMPLER_ROUNDING_EN: linear mode rounds half up instead of flooring.
module multichan_resampler
   import interp_pkg::*;
#(
   parameter int INW      = 16,
   parameter int NCH      = 2,
   parameter int CTRBITS  = 32,
   parameter int FRACBITS = 8
) (
   input  logic                               i_clk,
   input  logic                               i_areset_n,
   input  logic                               i_ce,
   input  logic [CTRBITS-1:0]                 i_step,
   input  logic [1:0]                         i_mode,
   input  logic [NCH*INW-1:0]                 i_data,
   output logic                               o_ce,
   output logic [NCH*INW-1:0]                 o_data,
   output logic [weight_width(FRACBITS)-1:0]  o_weight
);

   localparam int WW = weight_width(FRACBITS);
   localparam logic [WW-1:0] FULL_W = WW'(1) << FRACBITS;

   logic [CTRBITS:0]   sum;
   logic [CTRBITS-1:0] ctr_q, ctr_d;
   logic               carry_d, carry_q;
   logic [WW-1:0]      w_d, w_q, o_weight_q;
   logic [1:0]         mode_q;
   logic               s1_vld_q, o_ce_q, upd;

   assign sum     = {1'b0, ctr_q} + {1'b0, i_step};
   assign carry_d = sum[CTRBITS];
   assign ctr_d   = sum[CTRBITS-1:0];
   // Weight on cur grows as the new phase lands closer to the wrap point
   assign w_d     = FULL_W - {1'b0, ctr_d[CTRBITS-1 -: FRACBITS]};
   assign upd     = s1_vld_q & carry_q;

   always_ff @(posedge i_clk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         ctr_q      <= '0;
         carry_q    <= 1'b0;
         w_q        <= '0;
         mode_q     <= MODE_HOLD;
         s1_vld_q   <= 1'b0;
         o_ce_q     <= 1'b0;
         o_weight_q <= '0;
      end else begin
         s1_vld_q <= i_ce;
         o_ce_q   <= upd;
         if (i_ce) begin
            ctr_q   <= ctr_d;
            carry_q <= carry_d;
            w_q     <= w_d;
            mode_q  <= i_mode;
         end
         if (upd) o_weight_q <= w_q;
      end
   end

   for (genvar k = 0; k < NCH; k++) begin : g_lane
      interp_lane #(
         .INW      (INW),
         .FRACBITS (FRACBITS)
      ) u_lane (
         .i_clk      (i_clk),
         .i_areset_n (i_areset_n),
         .i_ce       (i_ce),
         .i_upd      (upd),
         .i_mode     (mode_q),
         .i_weight   (w_q),
         .i_data     (i_data[k*INW +: INW]),
         .o_data     (o_data[k*INW +: INW])
      );
   end

   assign o_ce     = o_ce_q;
   assign o_weight = o_weight_q;

endmodule

// File: tb/tb_multichan_resampler.sv
// Randomised and directed bench for multichan_resampler against a phase/arithmetic model.
module tb_multichan_resampler;

   localparam int INW = 8, NCH = 2, CTRBITS = 8, FRACBITS = 4;
   localparam int FULL = 1 << FRACBITS, HALF = 1 << (FRACBITS - 1), MOD = 1 << CTRBITS;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 ce;
   logic [CTRBITS-1:0]   step;
   logic [1:0]           mode;
   logic [NCH*INW-1:0]   data;
   logic                 o_ce;
   logic [NCH*INW-1:0]   o_data;
   logic [FRACBITS:0]    o_weight;

   multichan_resampler #(.INW(INW), .NCH(NCH), .CTRBITS(CTRBITS), .FRACBITS(FRACBITS)) dut (
      .i_clk(clk), .i_areset_n(rst_n), .i_ce(ce), .i_step(step), .i_mode(mode),
      .i_data(data), .o_ce(o_ce), .o_data(o_data), .o_weight(o_weight));

   always #5 clk = ~clk;

   typedef struct {int c; int d0; int d1; int w;} exp_t;
   exp_t q[$];
   int cyc = 0, n_chk = 0, n_err = 0;
   int hd0 = 0, hd1 = 0, hw = 0;
   int obs_cnt = 0, obs_d0 = 0, obs_d1 = 0, obs_w = 0;
   int m_ctr = 0;
   int m_cur[NCH] = '{0, 0};
   int base;

   function automatic int f_out(int md, int p, int c, int w);
      int pr;
      if (md == 1) return (w >= HALF) ? c : p;
      if (md == 2) begin
         pr = (c - p) * w;
`ifdef RESAMPLER_ROUNDING_EN
         pr = pr + HALF;
`endif
         return p + (pr >>> FRACBITS);
      end
      return c;
   endfunction

   function automatic int lane(int k);
      logic [INW-1:0] v;
      v = o_data[k*INW +: INW];
      return int'($signed(v));
   endfunction

   task automatic cmp(string nm, int act, int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic check_cycle();
      exp_t e;
      if (!rst_n) begin
         q.delete();
         hd0 = 0; hd1 = 0; hw = 0;
      end
      if (q.size() > 0 && q[0].c == cyc) begin
         e = q.pop_front();
         cmp("o_ce", int'(o_ce), 1);
         cmp("lane0", lane(0), e.d0);
         cmp("lane1", lane(1), e.d1);
         cmp("weight", int'(o_weight), e.w);
         hd0 = e.d0; hd1 = e.d1; hw = e.w;
      end else begin
         cmp("o_ce_idle", int'(o_ce), 0);
         cmp("hold_lane0", lane(0), hd0);
         cmp("hold_lane1", lane(1), hd1);
         cmp("hold_weight", int'(o_weight), hw);
      end
      if (o_ce) begin
         obs_cnt++;
         obs_d0 = lane(0); obs_d1 = lane(1); obs_w = int'(o_weight);
      end
   endtask

   task automatic step_in(bit c, int st, int md, int d0, int d1);
      int nw, w, e0, e1;
      @(negedge clk);
      cyc++;
      check_cycle();
      ce = c; step = CTRBITS'(st); mode = 2'(md);
      data = {INW'(d1), INW'(d0)};
      if (c && rst_n) begin
         nw = m_ctr + st;
         m_ctr = nw % MOD;
         w = FULL - (m_ctr >> (CTRBITS - FRACBITS));
         e0 = f_out(md, m_cur[0], d0, w);
         e1 = f_out(md, m_cur[1], d1, w);
         m_cur[0] = d0; m_cur[1] = d1;
         if (nw >= MOD) q.push_back('{cyc + 2, e0, e1, w});
      end
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) step_in(0, 0, 0, 0, 0);
   endtask

   // Asserted between clock edges; outputs must clear without waiting for a clock
   task automatic async_reset();
      #3 rst_n = 1'b0;
      #1;
      cmp("rst_o_ce", int'(o_ce), 0);
      cmp("rst_o_data", int'(o_data), 0);
      cmp("rst_o_weight", int'(o_weight), 0);
      ce = 1'b0;
      m_ctr = 0; m_cur = '{0, 0};
      idle(2);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; ce = 1'b0; step = '0; mode = '0; data = '0;
      #1;
      cmp("init_o_ce", int'(o_ce), 0);
      cmp("init_o_data", int'(o_data), 0);
      idle(2);
      rst_n = 1'b1;

      cmp("model_lin", f_out(2, 16, 48, 8), 32);
      cmp("model_lin_neg", f_out(2, -20, 20, 8), 0);
      cmp("model_nearest_lo", f_out(1, 16, 48, 4), 16);

      // exact landing on zero: w=16, out=cur
      idle(1); async_reset(); base = obs_cnt;
      step_in(1, 'h80, 2, 16, 0); step_in(1, 'h80, 2, 48, 0); idle(3);
      cmp("s80_count", obs_cnt - base, 1);
      cmp("s80_out", obs_d0, 48);
      cmp("s80_w", obs_w, 16);

      async_reset();
      step_in(1, 'hC0, 2, 16, -20); step_in(1, 'hC0, 2, 48, 20); idle(3);
      cmp("sC0_lin0", obs_d0, 32);
      cmp("sC0_lin1", obs_d1, 0);
      cmp("sC0_w", obs_w, 8);

      async_reset();
      step_in(1, 'hC0, 1, 16, 0); step_in(1, 'hC0, 1, 48, 0); idle(3);
      cmp("sC0_near", obs_d0, 48);
      async_reset();
      step_in(1, 'hA0, 1, 16, 0); step_in(1, 'hA0, 1, 48, 0); idle(3);
      cmp("sA0_near", obs_d0, 48);
      cmp("sA0_w", obs_w, 12);
      async_reset();
      step_in(1, 'hE0, 1, 16, 0); step_in(1, 'hE0, 1, 48, 0); idle(3);
      cmp("sE0_near", obs_d0, 16);
      cmp("sE0_w", obs_w, 4);

      async_reset(); base = obs_cnt;
      for (int i = 0; i < 20; i++) step_in(1, 0, 2, i, -i);
      idle(3);
      cmp("step0_count", obs_cnt - base, 0);

      async_reset(); base = obs_cnt;
      for (int i = 0; i < 10; i++) step_in(1, 'hFF, 0, i * 3, -i);
      idle(3);
      cmp("stepFF_count", obs_cnt - base, 9);

      async_reset();
      step_in(1, 'hC0, 2, 0, 0); step_in(1, 'hC0, 2, 1, 0); idle(3);
`ifdef RESAMPLER_ROUNDING_EN
      cmp("round_half", obs_d0, 1);
`else
      cmp("round_half", obs_d0, 0);
`endif

      // reset with samples in flight: nothing may emerge afterwards
      for (int i = 0; i < 4; i++) step_in(1, 'hFF, 2, 10 + i, 20 - i);
      async_reset(); base = obs_cnt;
      idle(4);
      cmp("post_rst_quiet", obs_cnt - base, 0);
      step_in(1, 'h80, 0, 5, 6); idle(3);
      cmp("post_rst_nocarry", obs_cnt - base, 0);
      step_in(1, 'h80, 0, 7, 8); idle(3);
      cmp("post_rst_carry", obs_cnt - base, 1);

      for (int i = 0; i < 1500; i++) begin
         int st;
         case ($urandom_range(0, 3))
            0: st = 0;
            1: st = 'hFF;
            2: st = 'h80;
            default: st = int'($urandom_range(0, MOD - 1));
         endcase
         step_in($urandom_range(0, 3) != 0, st, int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
         if (i == 700) async_reset();
      end
      idle(4);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/multichan_resampler.md
Name: multichan_resampler

Overview:
- Parametrised successor to the single-channel nearest-neighbour decimator.
- Resamples NCH lanes of signed samples that share one input strobe, using a phase accumulator.
- Run-time mode select: sample hold, true nearest-neighbour, or first-order linear interpolation.
- Sits between an upstream sample source (strobed by i_ce) and a slower downstream consumer.

Parameters:
- INW, 16, signed sample width per lane
- NCH, 2, number of lanes sharing one phase
- CTRBITS, 32, phase accumulator width
- FRACBITS, 8, interpolation weight resolution; must be >=1 and <=CTRBITS

Ports:
- i_clk  in  1  clock
- i_areset_n  in  1  reset, asynchronous, active-low
- i_ce  in  1  input sample strobe
- i_step  in  CTRBITS  phase increment per input sample
- i_mode  in  2  0=hold latest, 1=nearest, 2=linear, 3=reserved (behaves as 0)
- i_data  in  NCH*INW  lane k in bits [k*INW +: INW], two's complement
- o_ce  out  1  output sample strobe, single-cycle pulse
- o_data  out  NCH*INW  resampled lanes, same packing as i_data
- o_weight  out  FRACBITS+1  weight w used for the current output

Behaviour:
- Interface: one clock, i_clk; reset is asynchronous and active-low, i_areset_n.
- Reset clears: counter=0, per-lane prev=0, pipeline valid bits=0, o_ce=0, o_data=0, o_weight=0.
- On each i_ce: {carry, counter} <= counter + i_step. i_step and i_mode are sampled only on i_ce.
- When i_ce is low, the counter holds its value.
- Stage 1, registered on i_ce:
  - captures cur=i_data, prev=the previous cur, carry, mode;
  - captures w = 2^FRACBITS - counter_new[CTRBITS-1 -: FRACBITS], range 1..2^FRACBITS, FRACBITS+1 bits.
- prev updates on every i_ce, whether or not carry is set.
- Stage 2 registers the output. o_ce is asserted only if stage 1 held carry.
- Latency: i_ce at cycle n -> o_ce at cycle n+2.
- Full throughput: i_ce may be high on every cycle.
- Result per mode, per lane:
  - Mode 0: out = cur.
  - Mode 1: out = cur if w >= 2^(FRACBITS-1), else prev.
  - Mode 2: out = prev + (((cur-prev)*w) >>> FRACBITS).
- Mode 2 width rules:
  - difference is INW+1 bits signed;
  - product is INW+FRACBITS+2 bits signed, using an arithmetic shift;
  - the sum is truncated to INW bits; no overflow is possible because w <= 2^FRACBITS.
- o_data and o_weight hold their values between o_ce pulses.
- At most one output per input. Upsampling beyond 1:1 is out of scope.
- step=0: no outputs ever.
- Counter wrap: carry is set iff counter+i_step >= 2^CTRBITS. An exact landing on 0 gives w=2^FRACBITS, so out=cur.
- The first input after reset interpolates against prev=0.
- Reset mid-operation discards in-flight pipeline samples; no o_ce follows reset until a new carry occurs.

Optional Feature:
- Macro: RESAMPLER_ROUNDING_EN.
- Defined: mode 2 adds 2^(FRACBITS-1) to the product before the shift (round half up).
- Undefined: truncation toward negative infinity.
- Modes 0 and 1 are unaffected by the macro.

Decomposition:
- Package interp_pkg holds:
  - mode constants MODE_HOLD=2'd0, MODE_NEAREST=2'd1, MODE_LINEAR=2'd2;
  - a weight-width helper function.
- Sub-module interp_lane: one per lane, via generate.
  - Contains the prev/cur registers and the stage-2 mode mux plus multiplier.
- The top level owns the counter, carry/weight/mode pipeline and o_ce.

Test Plan:
All tests use INW=8, CTRBITS=8, FRACBITS=4, NCH=2.
- Reset: drive i_areset_n low asynchronously mid-stream -> all outputs 0 immediately; no o_ce until the next carry.
- Step 0x80, mode 2, lane0 inputs 16 then 48 -> counter 0x80 then 0x00; one o_ce two cycles after the second i_ce; w=16; out=48.
- Step 0xC0, mode 2, prev=16, cur=48 -> counter 0xC0 then 0x80, w=8, out=32. Lane1 prev=-20, cur=20 -> out 0.
- Same stimulus, mode 1 -> out=48 (w=8 >= 8). With step 0xA0 (counter 0xA0 then 0x40, w=12) -> out=48. With step 0xE0 -> out=prev.
- Step 0x00 with 20 consecutive i_ce -> zero o_ce. Step 0xFF with back-to-back i_ce -> o_ce on every input except the first.
- Rounding: mode 2, prev=0, cur=1, w=8 -> out=0 with the macro undefined, 1 with RESAMPLER_ROUNDING_EN defined.
